mem_bus_router: RTL

// - Downstream of the CPU memory-bus wrapper: takes the single shared valid/ready bus and routes each transfer
//   to on-chip RAM, the peripheral port, or an error responder.
// - Adds a peripheral timeout watchdog and sticky error capture, so a hung or unmapped access never stalls the CPU.

---
 rtl/mem_bus_router_pkg.sv | 28 ++
 rtl/mem_bus_router_bus_timeout_ctr.sv | 27 ++
 rtl/mem_bus_router.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_router_pkg.sv
// Shared memory-map defaults, FSM state encoding and error-log record for the bus router.
package mem_bus_router_pkg;

    localparam logic [31:0] RAM_BASE_DEF  = 32'h0000_0000;
    localparam int          RAM_AW_DEF    = 14;
    localparam logic [31:0] PER_BASE_DEF  = 32'h8000_0000;
    localparam int          PER_AW_DEF    = 16;
    localparam int          TIMEOUT_DEF   = 255;
    localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RAM_RESP = 2'd1,
        ST_PER_WAIT = 2'd2,
        ST_RESP     = 2'd3
    } state_e;

    typedef struct packed {
        logic was_timeout;
        logic was_instr;
    } err_info_t;

    // A window of 2**aw bytes matches when every address bit above the window size agrees with its base.
    function automatic logic region_hit(input logic [31:0] addr, input logic [31:0] base, input int aw);
        return (addr >> aw) == (base >> aw);
    endfunction

endpackage

// File: rtl/mem_bus_router_bus_timeout_ctr.sv
// Peripheral watchdog: counts enabled cycles from a clear and flags the last permitted wait cycle.
module bus_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int             W    = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0]   LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            cnt_reg <= '0;
        end else if (en && !expired) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign expired = (cnt_reg == LAST);

endmodule

// File: rtl/mem_bus_router.sv
// Routes the shared CPU valid/ready bus to RAM, the peripheral port or an error responder,
// with a peripheral watchdog and a sticky first-error log.
module mem_bus_router
    import mem_bus_router_pkg::*;
#(
    parameter logic [31:0] RAM_BASE  = RAM_BASE_DEF,
    parameter int          RAM_AW    = RAM_AW_DEF,
    parameter logic [31:0] PER_BASE  = PER_BASE_DEF,
    parameter int          PER_AW    = PER_AW_DEF,
    parameter int          TIMEOUT   = TIMEOUT_DEF,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_valid,
    input  logic              mem_instr,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,
    output logic              ram_en,
    output logic [RAM_AW-3:0] ram_addr,
    output logic [3:0]        ram_wstrb,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              per_valid,
    output logic [PER_AW-1:0] per_addr,
    output logic [3:0]        per_wstrb,
    output logic [31:0]       per_wdata,
    input  logic              per_ready,
    input  logic [31:0]       per_rdata,
    output logic              err_valid,
    output logic [31:0]       err_addr,
    output logic [1:0]        err_info,
    input  logic              err_clr
);

    state_e      state_reg;
    logic        mem_ready_reg;
    logic [31:0] rdata_reg;
    logic        per_valid_reg;
    logic [31:0] req_addr_reg;
    logic [3:0]  req_wstrb_reg;
    logic [31:0] req_wdata_reg;
    logic        req_instr_reg;

    logic        err_valid_reg;
    logic [31:0] err_addr_reg;
    err_info_t   err_info_reg;

    logic        ram_hit;
    logic        per_hit;
    logic        accept;
    logic        unmapped_now;
    logic        timeout_now;
    logic        err_set;
    logic [31:0] err_addr_next;
    err_info_t   err_info_next;

    logic        ctr_clr;
    logic        ctr_en;
    logic        ctr_expired;

    assign ram_hit      = region_hit(mem_addr, RAM_BASE, RAM_AW);
    assign per_hit      = region_hit(mem_addr, PER_BASE, PER_AW);
    assign accept       = (state_reg == ST_IDLE) && mem_valid;
    assign unmapped_now = accept && !ram_hit && !per_hit;
    assign timeout_now  = (state_reg == ST_PER_WAIT) && !per_ready && ctr_expired;
    assign err_set      = unmapped_now || timeout_now;

    // RAM is strobed straight from the request so its registered read lines up with RAM_RESP.
    assign ram_en    = accept && ram_hit;
    assign ram_addr  = mem_addr[RAM_AW-1:2];
    assign ram_wstrb = mem_wstrb;
    assign ram_wdata = mem_wdata;

    assign per_valid = per_valid_reg;
    assign per_addr  = req_addr_reg[PER_AW-1:0];
    assign per_wstrb = req_wstrb_reg;
    assign per_wdata = req_wdata_reg;

    assign mem_ready = mem_ready_reg;
    assign mem_rdata = (state_reg == ST_RAM_RESP) ? ram_rdata : rdata_reg;

    assign err_valid = err_valid_reg;
    assign err_addr  = err_addr_reg;
    assign err_info  = err_info_reg;

    assign ctr_clr = (state_reg != ST_PER_WAIT);
    assign ctr_en  = (state_reg == ST_PER_WAIT) && !per_ready;

    bus_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (ctr_clr),
        .en      (ctr_en),
        .expired (ctr_expired)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg     <= ST_IDLE;
            mem_ready_reg <= 1'b0;
            rdata_reg     <= '0;
            per_valid_reg <= 1'b0;
            req_addr_reg  <= '0;
            req_wstrb_reg <= '0;
            req_wdata_reg <= '0;
            req_instr_reg <= 1'b0;
        end else begin
            mem_ready_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (mem_valid) begin
                        if (ram_hit) begin
                            mem_ready_reg <= 1'b1;
                            state_reg     <= ST_RAM_RESP;
                        end else if (per_hit) begin
                            req_addr_reg  <= mem_addr;
                            req_wstrb_reg <= mem_wstrb;
                            req_wdata_reg <= mem_wdata;
                            req_instr_reg <= mem_instr;
                            per_valid_reg <= 1'b1;
                            state_reg     <= ST_PER_WAIT;
                        end else begin
                            rdata_reg     <= ERR_RDATA;
                            mem_ready_reg <= 1'b1;
                            state_reg     <= ST_RESP;
                        end
                    end
                end
                ST_PER_WAIT: begin
                    // A response arriving in the last permitted cycle still beats the watchdog.
                    if (per_ready) begin
                        rdata_reg     <= per_rdata;
                        per_valid_reg <= 1'b0;
                        mem_ready_reg <= 1'b1;
                        state_reg     <= ST_RESP;
                    end else if (ctr_expired) begin
                        rdata_reg     <= ERR_RDATA;
                        per_valid_reg <= 1'b0;
                        mem_ready_reg <= 1'b1;
                        state_reg     <= ST_RESP;
                    end
                end
                ST_RAM_RESP: state_reg <= ST_IDLE;
                ST_RESP:     state_reg <= ST_IDLE;
                default:     state_reg <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        err_addr_next = mem_addr;
        err_info_next = '{was_timeout: 1'b0, was_instr: mem_instr};
        if (timeout_now) begin
            err_addr_next = req_addr_reg;
            err_info_next = '{was_timeout: 1'b1, was_instr: req_instr_reg};
        end
    end

    // The first error is kept until cleared; a clear coinciding with a new error makes room for it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_valid_reg <= 1'b0;
            err_addr_reg  <= '0;
            err_info_reg  <= '0;
        end else begin
            if (err_set && (!err_valid_reg || err_clr)) begin
                err_addr_reg <= err_addr_next;
                err_info_reg <= err_info_next;
            end
            if (err_set) begin
                err_valid_reg <= 1'b1;
            end else if (err_clr) begin
                err_valid_reg <= 1'b0;
            end
        end
    end

endmodule
